// File: rtl/frame_ram_read_arbiter.sv
// Round-robin arbiter that shares one frame RAM read port between two requesters
// and routes each returned word back to its issuer. Optional stats: FRAME_ARB_STATS_EN.
module frame_ram_read_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int RAM_LATENCY = 1
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic              iEnable,
    input  logic              iReq0,
    input  logic [ADDR_W-1:0] iAddr0,
    input  logic              iReq1,
    input  logic [ADDR_W-1:0] iAddr1,
    output logic              oGrant0,
    output logic              oGrant1,
    output logic [ADDR_W-1:0] oReadAddr,
    input  logic [DATA_W-1:0] iRamData,
    output logic [DATA_W-1:0] oData0,
    output logic              oValid0,
    output logic [DATA_W-1:0] oData1,
    output logic              oValid1,
    output logic              oBusy
`ifdef FRAME_ARB_STATS_EN
    ,
    output logic [31:0]       oGrantCount0,
    output logic [31:0]       oGrantCount1,
    output logic [31:0]       oConflictCount
`endif
);

    // ptr holds the index of the last granted requester; the other one wins contention
    logic                   ptr;
    logic                   grant_en;
    logic                   grant_any;
    logic                   grant_id;
    logic [ADDR_W-1:0]      last_addr;
    logic [RAM_LATENCY-1:0] tag_vld;
    logic [RAM_LATENCY-1:0] tag_id;
    logic                   ret_vld;
    logic                   ret_id;

    always_comb begin
        grant_en = iEnable & ~iReset;
        oGrant0  = grant_en & iReq0 & (~iReq1 | ptr);
        oGrant1  = grant_en & iReq1 & (~iReq0 | ~ptr);
        grant_any = oGrant0 | oGrant1;
        grant_id  = oGrant1;
        if (oGrant0)
            oReadAddr = iAddr0;
        else if (oGrant1)
            oReadAddr = iAddr1;
        else
            oReadAddr = last_addr;
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            ptr       <= 1'b1;
            last_addr <= '0;
        end else if (grant_any) begin
            ptr       <= grant_id;
            last_addr <= oReadAddr;
        end
    end

    // one tag per RAM pipeline stage; the last stage lines up with q
    always_ff @(posedge iClock) begin
        if (iReset) begin
            tag_vld <= '0;
            tag_id  <= '0;
        end else begin
            tag_vld[0] <= grant_any;
            tag_id[0]  <= grant_id;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end
        end
    end

    assign ret_vld = tag_vld[RAM_LATENCY-1];
    assign ret_id  = tag_id[RAM_LATENCY-1];
    assign oBusy   = |tag_vld;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            oValid0 <= 1'b0;
            oValid1 <= 1'b0;
            oData0  <= '0;
            oData1  <= '0;
        end else begin
            oValid0 <= ret_vld & ~ret_id;
            oValid1 <= ret_vld & ret_id;
            if (ret_vld && !ret_id)
                oData0 <= iRamData;
            if (ret_vld && ret_id)
                oData1 <= iRamData;
        end
    end

`ifdef FRAME_ARB_STATS_EN
    logic conflict;
    assign conflict = iEnable & iReq0 & iReq1;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            oGrantCount0   <= '0;
            oGrantCount1   <= '0;
            oConflictCount <= '0;
        end else begin
            if (oGrant0 && oGrantCount0 != '1)
                oGrantCount0 <= oGrantCount0 + 32'd1;
            if (oGrant1 && oGrantCount1 != '1)
                oGrantCount1 <= oGrantCount1 + 32'd1;
            if (conflict && oConflictCount != '1)
                oConflictCount <= oConflictCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_frame_ram_read_arbiter.sv
// Randomized bench for frame_ram_read_arbiter against a queue-based return model;
// RAM contents are mem[a] = a*3.
module tb_frame_ram_read_arbiter;
    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst, en, r0, r1;
    logic [15:0] a0, a1;
    logic        g0, g1, v0, v1, busy;
    logic [15:0] raddr, rdata, d0, d1;
`ifdef FRAME_ARB_STATS_EN
    logic [31:0] gc0, gc1, cc;
`endif

    always #5 clk = ~clk;

    frame_ram_read_arbiter #(.ADDR_W(16), .DATA_W(16), .RAM_LATENCY(LAT)) dut (
        .iClock(clk), .iReset(rst), .iEnable(en),
        .iReq0(r0), .iAddr0(a0), .iReq1(r1), .iAddr1(a1),
        .oGrant0(g0), .oGrant1(g1), .oReadAddr(raddr), .iRamData(rdata),
        .oData0(d0), .oValid0(v0), .oData1(d1), .oValid1(v1), .oBusy(busy)
`ifdef FRAME_ARB_STATS_EN
        , .oGrantCount0(gc0), .oGrantCount1(gc1), .oConflictCount(cc)
`endif
    );

    function automatic logic [15:0] mem_f(input logic [15:0] a);
        return 16'(a * 3);
    endfunction

    // RAM with LAT cycles of read latency
    logic [15:0] rq [LAT];
    always @(posedge clk) begin
        rq[0] <= mem_f(raddr);
        for (int i = 1; i < LAT; i++) rq[i] <= rq[i-1];
    end
    assign rdata = rq[LAT-1];

    typedef struct {
        int          due;
        bit          id;
        logic [15:0] data;
    } ret_t;

    ret_t        q[$];
    int          cyc, total, bad;
    bit          last_win;
    logic [15:0] m_addr, m_d0, m_d1;
    bit          m_g0, m_g1;
    int unsigned m_c0, m_c1, m_cc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last_win = 1'b1;
        m_addr = '0; m_d0 = '0; m_d1 = '0;
        m_c0 = 0; m_c1 = 0; m_cc = 0;
        m_g0 = 0; m_g1 = 0;
    endtask

    // one clock cycle: drive, check against model, advance model across the edge
    task automatic step(input bit e, input bit rs, input bit q0, input logic [15:0] ad0,
                        input bit q1, input logic [15:0] ad1);
        bit act, win, any, ev0, ev1, eb;
        logic [15:0] ea;
        en = e; rst = rs; r0 = q0; a0 = ad0; r1 = q1; a1 = ad1;
        #1;
        act = e && !rs;
        any = act && (q0 || q1);
        if (q0 && q1) win = !last_win;
        else          win = q1;
        m_g0 = any && !win;
        m_g1 = any && win;
        ea = !any ? m_addr : (win ? ad1 : ad0);
        chk("grant0", 32'(g0), 32'(m_g0));
        chk("grant1", 32'(g1), 32'(m_g1));
        chk("raddr", 32'(raddr), 32'(ea));

        ev0 = 0; ev1 = 0;
        if (q.size() > 0 && q[0].due == cyc) begin
            if (q[0].id) begin ev1 = 1; m_d1 = q[0].data; end
            else         begin ev0 = 1; m_d0 = q[0].data; end
            void'(q.pop_front());
        end
        eb = 0;
        foreach (q[i]) if (cyc >= q[i].due - LAT && cyc < q[i].due) eb = 1;
        chk("valid0", 32'(v0), 32'(ev0));
        chk("valid1", 32'(v1), 32'(ev1));
        chk("data0", 32'(d0), 32'(m_d0));
        chk("data1", 32'(d1), 32'(m_d1));
        chk("busy", 32'(busy), 32'(eb));
`ifdef FRAME_ARB_STATS_EN
        chk("gcnt0", gc0, m_c0);
        chk("gcnt1", gc1, m_c1);
        chk("ccnt", cc, m_cc);
`endif

        if (rs) begin
            model_reset();
        end else begin
            if (e && q0 && q1) m_cc++;
            if (any) begin
                q.push_back('{cyc + LAT + 1, win, mem_f(ea)});
                last_win = win;
                m_addr = ea;
                if (win) m_c1++; else m_c0++;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 16'h0, 0, 16'h0);
    endtask

    initial begin
        bit hold0, hold1, nr0, nr1, ne, nrs;
        logic [15:0] ha0, ha1;
        total = 0; bad = 0; cyc = 0;
        en = 0; r0 = 0; r1 = 0; a0 = 0; a1 = 0; rst = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // single requester, mem[0x10] = 0x30 two cycles after grant
        step(1, 0, 1, 16'h0010, 0, 16'h0);
        idle(3);
        // continuous contention from reset
        step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 1, 16'h0100, 1, 16'h0200);
        idle(3);
        // requester 1 alone, then requester 0 joins
        step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 16'h0, 1, 16'(16'h0300 + i));
        for (int i = 0; i < 6; i++) step(1, 0, 1, 16'h0400, 1, 16'h0500);
        // three grants then enable drops with requests still pending
        for (int i = 0; i < 3; i++) step(1, 0, 1, 16'(16'h0600 + i), 0, 16'h0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 16'h0700, 1, 16'h0800);
        // reset right after a grant drops the read
        step(1, 0, 1, 16'h0900, 0, 16'h0);
        step(1, 1, 0, 16'h0, 0, 16'h0);
        idle(3);
        // ten contended cycles for the stats counters
        step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 1, 16'h0a00, 1, 16'h0b00);
        idle(3);

        hold0 = 0; hold1 = 0; ha0 = 0; ha1 = 0;
        for (int n = 0; n < 2000; n++) begin
            nrs = ($urandom_range(0, 99) == 0);
            ne  = ($urandom_range(0, 9) != 0);
            nr0 = hold0 ? 1'b1 : 1'($urandom_range(0, 1));
            nr1 = hold1 ? 1'b1 : 1'($urandom_range(0, 1));
            if (!hold0) ha0 = 16'($urandom);
            if (!hold1) ha1 = 16'($urandom);
            step(ne, nrs, nr0, ha0, nr1, ha1);
            hold0 = nr0 && !m_g0 && !nrs;
            hold1 = nr1 && !m_g1 && !nrs;
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
